// File: rtl/role_axi_decoupler.sv
// AXI4 decoupler between a role master port and the shell: zero-latency pass-through,
// per-direction outstanding limits, and drain-then-isolate on decouple_req.
module role_axi_decoupler #(
  parameter int unsigned ADDR_WIDTH      = 36,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    decouple_req,
  output logic                    decouple_ack,
  output logic [CNT_W-1:0]        rd_outstanding,
  output logic [CNT_W-1:0]        wr_outstanding,
  output logic                    err_underflow,
  // role side
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // shell side
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  typedef enum logic [1:0] {StPass, StDrain, StDecoupled} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_rd_cnt, r_wr_cnt, r_w_owed;
  logic [CNT_W-1:0] w_rd_cnt_d, w_wr_cnt_d, w_w_owed_d;
  logic             r_err;
  logic             w_ar_hs, w_aw_hs, w_w_done, w_r_done, w_b_done;
  logic             w_rd_uf, w_wr_uf;

  assign {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
          m_axi_arprot, m_axi_arqos} = {s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
          s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  assign {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
          m_axi_awprot, m_axi_awqos} = {s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
          s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {s_axi_rdata, s_axi_rresp, s_axi_rlast} = {m_axi_rdata, m_axi_rresp, m_axi_rlast};
  assign s_axi_bresp = m_axi_bresp;

  // Gating uses only registered state/counters, so no valid->ready path is created.
  always_comb begin
    m_axi_arvalid = 1'b0;
    s_axi_arready = 1'b0;
    m_axi_awvalid = 1'b0;
    s_axi_awready = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (r_state)
      StPass: begin
        m_axi_arvalid = s_axi_arvalid & (r_rd_cnt < MaxCnt);
        s_axi_arready = m_axi_arready & (r_rd_cnt < MaxCnt);
        m_axi_awvalid = s_axi_awvalid & (r_wr_cnt < MaxCnt);
        s_axi_awready = m_axi_awready & (r_wr_cnt < MaxCnt);
        m_axi_wvalid  = s_axi_wvalid;
        s_axi_wready  = m_axi_wready;
        s_axi_rvalid  = m_axi_rvalid;
        m_axi_rready  = s_axi_rready;
        s_axi_bvalid  = m_axi_bvalid;
        m_axi_bready  = s_axi_bready;
      end
      StDrain: begin
        m_axi_wvalid  = s_axi_wvalid & (r_w_owed != '0);
        s_axi_wready  = m_axi_wready & (r_w_owed != '0);
        s_axi_rvalid  = m_axi_rvalid;
        m_axi_rready  = s_axi_rready;
        s_axi_bvalid  = m_axi_bvalid;
        m_axi_bready  = s_axi_bready;
      end
      default: ;
    endcase
  end

  assign w_ar_hs  = m_axi_arvalid & m_axi_arready;
  assign w_aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_w_done = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign w_r_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign w_b_done = m_axi_bvalid & m_axi_bready;

  assign w_rd_uf = w_r_done & ~w_ar_hs & (r_rd_cnt == '0);
  assign w_wr_uf = w_b_done & ~w_aw_hs & (r_wr_cnt == '0);

  // Decrement at zero saturates; the error flag is raised separately.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + CNT_W'(1);
    end else if (!inc && dec && cnt != '0) begin
      nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

  assign w_rd_cnt_d = cnt_next(r_rd_cnt, w_ar_hs, w_r_done);
  assign w_wr_cnt_d = cnt_next(r_wr_cnt, w_aw_hs, w_b_done);
  assign w_w_owed_d = cnt_next(r_w_owed, w_aw_hs, w_w_done);

  // Drain completion looks at next-cycle counts so ack rises right after the final handshake.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StPass: if (decouple_req) w_state_d = StDrain;
      StDrain: begin
        if (!decouple_req) begin
          w_state_d = StPass;
        end else if (w_rd_cnt_d == '0 && w_wr_cnt_d == '0 && w_w_owed_d == '0) begin
          w_state_d = StDecoupled;
        end
      end
      StDecoupled: if (!decouple_req) w_state_d = StPass;
      default: w_state_d = StPass;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= StPass;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_w_owed <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rd_cnt <= w_rd_cnt_d;
      r_wr_cnt <= w_wr_cnt_d;
      r_w_owed <= w_w_owed_d;
      r_err    <= r_err | w_rd_uf | w_wr_uf;
    end
  end

  assign decouple_ack   = (r_state == StDecoupled);
  assign rd_outstanding = r_rd_cnt;
  assign wr_outstanding = r_wr_cnt;
  assign err_underflow  = r_err;

endmodule

// File: tb/tb_role_axi_decoupler.sv
// Bench for role_axi_decoupler: directed scenarios with literal checks, then random traffic,
// all checked every cycle against a queue/integer model of the decoupler rules.
module tb_role_axi_decoupler;
  localparam int AW = 36;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MAX = 4;
  localparam int CW = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic areset, decouple_req, decouple_ack, err_underflow;
  logic [CW-1:0] rd_outstanding, wr_outstanding;

  logic [AW-1:0] s_axi_araddr, m_axi_araddr, s_axi_awaddr, m_axi_awaddr;
  logic [7:0] s_axi_arlen, m_axi_arlen, s_axi_awlen, m_axi_awlen;
  logic [2:0] s_axi_arsize, m_axi_arsize, s_axi_awsize, m_axi_awsize;
  logic [1:0] s_axi_arburst, m_axi_arburst, s_axi_awburst, m_axi_awburst;
  logic s_axi_arlock, m_axi_arlock, s_axi_awlock, m_axi_awlock;
  logic [3:0] s_axi_arcache, m_axi_arcache, s_axi_awcache, m_axi_awcache;
  logic [2:0] s_axi_arprot, m_axi_arprot, s_axi_awprot, m_axi_awprot;
  logic [3:0] s_axi_arqos, m_axi_arqos, s_axi_awqos, m_axi_awqos;
  logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic [SW-1:0] s_axi_wstrb, m_axi_wstrb;
  logic s_axi_wlast, m_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
  logic [1:0] s_axi_rresp, m_axi_rresp, s_axi_bresp, m_axi_bresp;
  logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;
  logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: outstanding counts, mode 0=pass 1=drain 2=decoupled, plus queues that steer stimulus.
  int rd_n = 0, wr_n = 0, wo_n = 0, mode = 0, bn = 0;
  bit err_m = 1'b0;
  int rdq[$];
  int wq[$];

  role_axi_decoupler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)) dut (
    .aclk(clk), .areset(areset), .decouple_req(decouple_req), .decouple_ack(decouple_ack),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_underflow(err_underflow),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
    .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model from the observed inputs.
  bit pass_m, ar_ok, aw_ok, w_ok, rb_ok;
  bit e_arv, e_arr, e_awv, e_awr, e_wv, e_wr, e_rv, e_rr, e_bv, e_br;
  bit ar_hs, aw_hs, w_hs, r_hs, b_hs, w_fin, r_fin;
  always @(negedge clk) begin
    pass_m = (mode == 0);
    ar_ok  = pass_m && (rd_n < MAX);
    aw_ok  = pass_m && (wr_n < MAX);
    w_ok   = pass_m || (mode == 1 && wo_n > 0);
    rb_ok  = (mode != 2);
    e_arv = s_axi_arvalid && ar_ok;  e_arr = m_axi_arready && ar_ok;
    e_awv = s_axi_awvalid && aw_ok;  e_awr = m_axi_awready && aw_ok;
    e_wv  = s_axi_wvalid && w_ok;    e_wr  = m_axi_wready && w_ok;
    e_rv  = m_axi_rvalid && rb_ok;   e_rr  = s_axi_rready && rb_ok;
    e_bv  = m_axi_bvalid && rb_ok;   e_br  = s_axi_bready && rb_ok;
    chk("m_arvalid", m_axi_arvalid, e_arv);  chk("s_arready", s_axi_arready, e_arr);
    chk("m_awvalid", m_axi_awvalid, e_awv);  chk("s_awready", s_axi_awready, e_awr);
    chk("m_wvalid", m_axi_wvalid, e_wv);     chk("s_wready", s_axi_wready, e_wr);
    chk("s_rvalid", s_axi_rvalid, e_rv);     chk("m_rready", m_axi_rready, e_rr);
    chk("s_bvalid", s_axi_bvalid, e_bv);     chk("m_bready", m_axi_bready, e_br);
    chk("ar_payload", {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
        m_axi_arcache, m_axi_arprot, m_axi_arqos}, {s_axi_araddr, s_axi_arlen, s_axi_arsize,
        s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos});
    chk("aw_payload", {m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
        m_axi_awcache, m_axi_awprot, m_axi_awqos}, {s_axi_awaddr, s_axi_awlen, s_axi_awsize,
        s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos});
    chk("w_payload", {m_axi_wdata, m_axi_wstrb, m_axi_wlast},
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast});
    chk("r_payload", {s_axi_rdata, s_axi_rresp, s_axi_rlast},
        {m_axi_rdata, m_axi_rresp, m_axi_rlast});
    chk("b_payload", s_axi_bresp, m_axi_bresp);
    chk("rd_outstanding", rd_outstanding, rd_n);
    chk("wr_outstanding", wr_outstanding, wr_n);
    chk("decouple_ack", decouple_ack, mode == 2);
    chk("err_underflow", err_underflow, err_m);

    if (areset) begin
      rd_n = 0; wr_n = 0; wo_n = 0; mode = 0; bn = 0; err_m = 1'b0;
      rdq.delete(); wq.delete();
    end else begin
      ar_hs = e_arv && m_axi_arready;  aw_hs = e_awv && m_axi_awready;
      w_hs  = e_wv && m_axi_wready;    r_hs  = m_axi_rvalid && e_rr;
      b_hs  = m_axi_bvalid && e_br;
      w_fin = w_hs && s_axi_wlast;     r_fin = r_hs && m_axi_rlast;
      if (ar_hs && !r_fin) rd_n++;
      else if (!ar_hs && r_fin) begin
        if (rd_n == 0) err_m = 1'b1; else rd_n--;
      end
      if (aw_hs && !b_hs) wr_n++;
      else if (!aw_hs && b_hs) begin
        if (wr_n == 0) err_m = 1'b1; else wr_n--;
      end
      if (aw_hs && !w_fin) wo_n++;
      else if (!aw_hs && w_fin && wo_n > 0) wo_n--;
      case (mode)
        0: if (decouple_req) mode = 1;
        1: if (!decouple_req) mode = 0;
           else if (rd_n == 0 && wr_n == 0 && wo_n == 0) mode = 2;
        default: if (!decouple_req) mode = 0;
      endcase
      if (r_hs && rdq.size() > 0) begin
        if (rdq[0] <= 1) void'(rdq.pop_front()); else rdq[0] = rdq[0] - 1;
      end
      if (w_hs && wq.size() > 0) begin
        if (wq[0] <= 1) begin void'(wq.pop_front()); bn++; end else wq[0] = wq[0] - 1;
      end
      if (b_hs && bn > 0) bn--;
      if (ar_hs) rdq.push_back(int'(s_axi_arlen) + 1);
      if (aw_hs) wq.push_back(int'(s_axi_awlen) + 1);
    end
  end

  task automatic rand_inputs();
    s_axi_araddr = {4'($urandom), 32'($urandom)};
    {s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot,
     s_axi_arqos} = 25'($urandom);
    s_axi_arlen = 8'($urandom_range(0, 3));
    s_axi_awaddr = {4'($urandom), 32'($urandom)};
    {s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot,
     s_axi_awqos} = 25'($urandom);
    s_axi_awlen = 8'($urandom_range(0, 3));
    s_axi_arvalid = 1'($urandom);  m_axi_arready = 1'($urandom);
    s_axi_awvalid = 1'($urandom);  m_axi_awready = 1'($urandom);
    s_axi_wdata = $urandom;  s_axi_wstrb = 4'($urandom);
    s_axi_wvalid = (wq.size() > 0) && 1'($urandom);
    s_axi_wlast = (wq.size() > 0) && (wq[0] == 1);
    m_axi_wready = 1'($urandom);
    m_axi_rdata = $urandom;  m_axi_rresp = 2'($urandom);
    m_axi_rvalid = (rdq.size() > 0) && 1'($urandom);
    m_axi_rlast = (rdq.size() > 0) && (rdq[0] == 1);
    s_axi_rready = 1'($urandom);
    m_axi_bresp = 2'($urandom);
    m_axi_bvalid = (bn > 0) && 1'($urandom);
    s_axi_bready = 1'($urandom);
    if ($urandom_range(0, 29) == 0) decouple_req = !decouple_req;
    areset = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    areset = 1'b1; decouple_req = 1'b0;
    {s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
     s_axi_arprot, s_axi_arqos, s_axi_arvalid, m_axi_arready} = '0;
    {s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
     s_axi_awprot, s_axi_awqos, s_axi_awvalid, m_axi_awready} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, m_axi_wready} = '0;
    {m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, s_axi_rready} = '0;
    {m_axi_bresp, m_axi_bvalid, s_axi_bready} = '0;
    step(); step();
    areset = 1'b0;
    chk("rst_ack", decouple_ack, 1'b0);
    chk("rst_rd", rd_outstanding, 0);
    chk("rst_wr", wr_outstanding, 0);
    chk("rst_err", err_underflow, 1'b0);

    // Pass-through and saturation at MAX=4.
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b1; s_axi_arlen = 8'd3; s_axi_araddr = 36'h9_1234_5670;
    #1 chk("pt_arvalid", m_axi_arvalid, 1'b1);
    chk("pt_arlen", m_axi_arlen, 8'd3);
    repeat (4) step();
    chk("sat_rd4", rd_outstanding, 4);
    chk("sat_arready", s_axi_arready, 1'b0);
    chk("sat_arvalid", m_axi_arvalid, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_axi_rready = 1'b1; m_axi_rdata = 32'hCAFE_F00D;
    #1 chk("pt_rdata", s_axi_rdata, 32'hCAFE_F00D);
    step();
    m_axi_rvalid = 1'b0;
    #1 chk("sat_rd3", rd_outstanding, 3);
    chk("sat_reopen", s_axi_arready, 1'b1);
    step();
    chk("sat_rd4b", rd_outstanding, 4);
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b1;
    repeat (4) step();
    m_axi_rvalid = 1'b0;
    chk("pt_rd0", rd_outstanding, 0);

    // Drain: two 8-beat writes and one read in flight.
    s_axi_awvalid = 1'b1; m_axi_awready = 1'b1; s_axi_awlen = 8'd7;
    s_axi_arvalid = 1'b1; s_axi_arlen = 8'd0;
    step();
    s_axi_arvalid = 1'b0;
    step();
    s_axi_awvalid = 1'b0; decouple_req = 1'b1;
    step();
    s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
    #1 chk("dr_arready", s_axi_arready, 1'b0);
    chk("dr_awready", s_axi_awready, 1'b0);
    chk("dr_awvalid", m_axi_awvalid, 1'b0);
    chk("dr_rd", rd_outstanding, 1);
    chk("dr_wr", wr_outstanding, 2);
    s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_axi_wlast = (i % 8 == 7);
      step();
    end
    s_axi_wlast = 1'b0;
    #1 chk("dr_wblock", m_axi_wvalid, 1'b0);
    chk("dr_wready", s_axi_wready, 1'b0);
    s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
    step(); step();
    m_axi_bvalid = 1'b0;
    chk("dr_wr0", wr_outstanding, 0);
    chk("dr_ack_pre", decouple_ack, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    step();
    chk("dr_ack", decouple_ack, 1'b1);
    chk("dec_rvalid", s_axi_rvalid, 1'b0);
    chk("dec_rready", m_axi_rready, 1'b0);
    chk("dec_arvalid", m_axi_arvalid, 1'b0);
    m_axi_rvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; decouple_req = 1'b0;
    step();
    chk("dec_release", decouple_ack, 1'b0);

    // Abort mid-drain.
    s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0; decouple_req = 1'b1;
    step();
    s_axi_arvalid = 1'b1;
    #1 chk("ab_block", s_axi_arready, 1'b0);
    decouple_req = 1'b0;
    step();
    chk("ab_resume", s_axi_arready, 1'b1);
    step();
    chk("ab_rd2", rd_outstanding, 2);
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b1;
    step(); step();

    // Underflow: extra rlast with nothing outstanding.
    step();
    m_axi_rvalid = 1'b0;
    chk("uf_err", err_underflow, 1'b1);
    chk("uf_rd0", rd_outstanding, 0);
    repeat (3) step();
    chk("uf_sticky", err_underflow, 1'b1);

    // Reset mid-burst.
    s_axi_arvalid = 1'b1;
    repeat (3) step();
    s_axi_arvalid = 1'b0;
    chk("mr_rd3", rd_outstanding, 3);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("mr_rd0", rd_outstanding, 0);
    chk("mr_ack", decouple_ack, 1'b0);
    chk("mr_err", err_underflow, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end
    areset = 1'b0; decouple_req = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
